// File: rtl/decode_execute_stage.sv
// Decode/execute pipeline register with operand forwarding, a 16-bit scalar ALU
// and a 16-lane 8-bit vector ALU.
module decode_execute_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic [19:0]  ctrl_in,
  input  logic [15:0]  srcA_in,
  input  logic [15:0]  srcB_in,
  input  logic [127:0] srcA_vector_in,
  input  logic [127:0] srcB_vector_in,
  input  logic [4:0]   rs1_decode,
  input  logic [4:0]   rs2_decode,
  input  logic [4:0]   rd_decode,
  input  logic [1:0]   fwd_sel_a,
  input  logic [1:0]   fwd_sel_b,
  input  logic [15:0]  writeback_data,
  input  logic [15:0]  alu_result_memory,
  output logic         wre_execute,
  output logic         vector_wre_execute,
  output logic         write_memory_enable_a_execute,
  output logic         write_memory_enable_b_execute,
  output logic         load_instruction,
  output logic [1:0]   select_writeback_data_mux_execute,
  output logic [1:0]   select_writeback_vector_data_mux_execute,
  output logic [4:0]   aluOp_execute,
  output logic [4:0]   aluVectorOp_execute,
  output logic [15:0]  srcA_out,
  output logic [15:0]  srcB_out,
  output logic [127:0] srcA_vector_out,
  output logic [127:0] srcB_vector_out,
  output logic [4:0]   rs1_execute,
  output logic [4:0]   rs2_execute,
  output logic [4:0]   rd_execute,
  output logic [15:0]  alu_src_b,
  output logic [15:0]  alu_result,
  output logic [127:0] alu_vector_result
);

  // Bit 0 of the control word carries no meaning.
  logic unused_ctrl_bit;
  assign unused_ctrl_bit = ctrl_in[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      wre_execute                              <= 1'b0;
      vector_wre_execute                       <= 1'b0;
      write_memory_enable_a_execute            <= 1'b0;
      write_memory_enable_b_execute            <= 1'b0;
      select_writeback_data_mux_execute        <= 2'b00;
      select_writeback_vector_data_mux_execute <= 2'b00;
      aluOp_execute                            <= 5'd0;
      aluVectorOp_execute                      <= 5'd0;
      load_instruction                         <= 1'b0;
      srcA_out                                 <= 16'd0;
      srcB_out                                 <= 16'd0;
      srcA_vector_out                          <= 128'd0;
      srcB_vector_out                          <= 128'd0;
      rs1_execute                              <= 5'd0;
      rs2_execute                              <= 5'd0;
      rd_execute                               <= 5'd0;
    end else begin
      wre_execute                              <= ctrl_in[19];
      vector_wre_execute                       <= ctrl_in[18];
      write_memory_enable_a_execute            <= ctrl_in[17];
      write_memory_enable_b_execute            <= ctrl_in[16];
      select_writeback_data_mux_execute        <= ctrl_in[15:14];
      select_writeback_vector_data_mux_execute <= ctrl_in[13:12];
      aluOp_execute                            <= ctrl_in[11:7];
      aluVectorOp_execute                      <= ctrl_in[6:2];
      load_instruction                         <= ctrl_in[1];
      srcA_out                                 <= srcA_in;
      srcB_out                                 <= srcB_in;
      srcA_vector_out                          <= srcA_vector_in;
      srcB_vector_out                          <= srcB_vector_in;
      rs1_execute                              <= rs1_decode;
      rs2_execute                              <= rs2_decode;
      rd_execute                               <= rd_decode;
    end
  end

  logic [15:0] operand_a;
  logic [15:0] operand_b;

  always_comb begin
    case (fwd_sel_a)
      2'b01:   operand_a = writeback_data;
      2'b10:   operand_a = alu_result_memory;
      default: operand_a = srcA_out;
    endcase
    case (fwd_sel_b)
      2'b01:   operand_b = writeback_data;
      2'b10:   operand_b = alu_result_memory;
      default: operand_b = srcB_out;
    endcase
  end

  assign alu_src_b = operand_b;

  always_comb begin
    alu_result = 16'd0;
    case (aluOp_execute)
      5'd0:    alu_result = operand_a + operand_b;
      5'd1:    alu_result = operand_a - operand_b;
      5'd2:    alu_result = operand_a & operand_b;
      5'd3:    alu_result = operand_a | operand_b;
      5'd4:    alu_result = operand_a ^ operand_b;
      5'd5:    alu_result = operand_a << operand_b[3:0];
      5'd6:    alu_result = operand_a >> operand_b[3:0];
      5'd7:    alu_result = operand_b;
      5'd8:    alu_result = operand_a;
      5'd9:    alu_result = operand_a * operand_b;
      5'd10:   alu_result = (operand_a < operand_b) ? 16'd1 : 16'd0;
      default: alu_result = 16'd0;
    endcase
  end

  function automatic logic [7:0] lane_alu(input logic [4:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    logic [7:0] r;
    r = 8'd0;
    case (op)
      5'd0:    r = a + b;
      5'd1:    r = a - b;
      5'd2:    r = a & b;
      5'd3:    r = a | b;
      5'd4:    r = a ^ b;
      5'd5:    r = a * b;
      5'd6:    r = a << b[2:0];
      5'd7:    r = a >> b[2:0];
      5'd8:    r = b;
      5'd9:    r = a;
      default: r = 8'd0;
    endcase
    return r;
  endfunction

  // Each lane is computed in isolation so no carry or shift crosses a byte.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_lane
      assign alu_vector_result[8*gi +: 8] =
        lane_alu(aluVectorOp_execute, srcA_vector_out[8*gi +: 8], srcB_vector_out[8*gi +: 8]);
    end
  endgenerate

endmodule

// File: tb/tb_decode_execute_stage.sv
// Scoreboard bench for decode_execute_stage: expectations are queued when a
// transaction is driven and compared one cycle later against the DUT.
module tb_decode_execute_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic [19:0]  ctrl_in;
  logic [15:0]  srcA_in, srcB_in;
  logic [127:0] srcA_vector_in, srcB_vector_in;
  logic [4:0]   rs1_decode, rs2_decode, rd_decode;
  logic [1:0]   fwd_sel_a, fwd_sel_b;
  logic [15:0]  writeback_data, alu_result_memory;
  logic         wre_execute, vector_wre_execute, write_memory_enable_a_execute;
  logic         write_memory_enable_b_execute, load_instruction;
  logic [1:0]   select_writeback_data_mux_execute, select_writeback_vector_data_mux_execute;
  logic [4:0]   aluOp_execute, aluVectorOp_execute;
  logic [15:0]  srcA_out, srcB_out;
  logic [127:0] srcA_vector_out, srcB_vector_out;
  logic [4:0]   rs1_execute, rs2_execute, rd_execute;
  logic [15:0]  alu_src_b, alu_result;
  logic [127:0] alu_vector_result;

  always #5 clk = ~clk;

  decode_execute_stage dut (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in),
    .srcA_in(srcA_in), .srcB_in(srcB_in),
    .srcA_vector_in(srcA_vector_in), .srcB_vector_in(srcB_vector_in),
    .rs1_decode(rs1_decode), .rs2_decode(rs2_decode), .rd_decode(rd_decode),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .writeback_data(writeback_data), .alu_result_memory(alu_result_memory),
    .wre_execute(wre_execute), .vector_wre_execute(vector_wre_execute),
    .write_memory_enable_a_execute(write_memory_enable_a_execute),
    .write_memory_enable_b_execute(write_memory_enable_b_execute),
    .load_instruction(load_instruction),
    .select_writeback_data_mux_execute(select_writeback_data_mux_execute),
    .select_writeback_vector_data_mux_execute(select_writeback_vector_data_mux_execute),
    .aluOp_execute(aluOp_execute), .aluVectorOp_execute(aluVectorOp_execute),
    .srcA_out(srcA_out), .srcB_out(srcB_out),
    .srcA_vector_out(srcA_vector_out), .srcB_vector_out(srcB_vector_out),
    .rs1_execute(rs1_execute), .rs2_execute(rs2_execute), .rd_execute(rd_execute),
    .alu_src_b(alu_src_b), .alu_result(alu_result), .alu_vector_result(alu_vector_result)
  );

  typedef struct {
    string        name;
    logic [19:0]  ctrl;
    logic [4:0]   rs1, rs2, rd;
    logic [15:0]  sa, sb, srcb, res;
    logic [127:0] va, vb, vres;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_passed = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_passed++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] scalar_model(input logic [4:0] op, input logic [15:0] a,
                                               input logic [15:0] b);
    logic [31:0] p;
    logic [31:0] w;
    p = 32'(a) * 32'(b);
    w = {16'd0, a};
    case (op)
      5'd0:  return 16'((32'(a) + 32'(b)) % 32'h10000);
      5'd1:  return 16'((32'h10000 + 32'(a) - 32'(b)) % 32'h10000);
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return 16'((w * (32'd1 << b[3:0])) % 32'h10000);
      5'd6:  return 16'(w / (32'd1 << b[3:0]));
      5'd7:  return b;
      5'd8:  return a;
      5'd9:  return p[15:0];
      5'd10: return (a < b) ? 16'd1 : 16'd0;
      default: return 16'd0;
    endcase
  endfunction

  function automatic logic [127:0] vector_model(input logic [4:0] op, input logic [127:0] va,
                                                input logic [127:0] vb);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      int a, b, v;
      a = int'(va[8*i +: 8]);
      b = int'(vb[8*i +: 8]);
      case (op)
        5'd0: v = (a + b) % 256;
        5'd1: v = (a - b + 256) % 256;
        5'd2: v = a & b;
        5'd3: v = a | b;
        5'd4: v = a ^ b;
        5'd5: v = (a * b) % 256;
        5'd6: v = (a * (1 << (b % 8))) % 256;
        5'd7: v = a / (1 << (b % 8));
        5'd8: v = b;
        5'd9: v = a;
        default: v = 0;
      endcase
      r[8*i +: 8] = 8'(v);
    end
    return r;
  endfunction

  function automatic logic [15:0] pick(input logic [1:0] sel, input logic [15:0] reg_val,
                                       input logic [15:0] wb, input logic [15:0] mem);
    if (sel == 2'b01) return wb;
    if (sel == 2'b10) return mem;
    return reg_val;
  endfunction

  task automatic drive(input string name, input logic rst, input logic [19:0] c,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [127:0] va, input logic [127:0] vb,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input logic [15:0] wb, input logic [15:0] mem);
    exp_t e;
    logic [15:0] opa;
    @(negedge clk);
    reset = rst; ctrl_in = c; srcA_in = a; srcB_in = b;
    srcA_vector_in = va; srcB_vector_in = vb;
    rs1_decode = r1; rs2_decode = r2; rd_decode = rd;
    fwd_sel_a = fa; fwd_sel_b = fb; writeback_data = wb; alu_result_memory = mem;
    e.name = name;
    e.ctrl = rst ? 20'd0 : (c & 20'hFFFFE);
    e.sa   = rst ? 16'd0 : a;
    e.sb   = rst ? 16'd0 : b;
    e.va   = rst ? 128'd0 : va;
    e.vb   = rst ? 128'd0 : vb;
    e.rs1  = rst ? 5'd0 : r1;
    e.rs2  = rst ? 5'd0 : r2;
    e.rd   = rst ? 5'd0 : rd;
    opa    = pick(fa, e.sa, wb, mem);
    e.srcb = pick(fb, e.sb, wb, mem);
    e.res  = scalar_model(e.ctrl[11:7], opa, e.srcb);
    e.vres = vector_model(e.ctrl[6:2], e.va, e.vb);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 128'd1, 128'd0);
      return;
    end
    e = sb_q.pop_front();
    check({e.name, ".ctrl"}, {wre_execute, vector_wre_execute, write_memory_enable_a_execute,
          write_memory_enable_b_execute, select_writeback_data_mux_execute,
          select_writeback_vector_data_mux_execute, aluOp_execute, aluVectorOp_execute,
          load_instruction, 1'b0}, e.ctrl);
    check({e.name, ".srcA_out"}, srcA_out, e.sa);
    check({e.name, ".srcB_out"}, srcB_out, e.sb);
    check({e.name, ".vec_ops"}, srcA_vector_out ^ {srcB_vector_out[63:0], srcB_vector_out[127:64]},
          e.va ^ {e.vb[63:0], e.vb[127:64]});
    check({e.name, ".regs"}, {rs1_execute, rs2_execute, rd_execute}, {e.rs1, e.rs2, e.rd});
    check({e.name, ".alu_src_b"}, alu_src_b, e.srcb);
    check({e.name, ".alu_result"}, alu_result, e.res);
    check({e.name, ".alu_vector_result"}, alu_vector_result, e.vres);
  endtask

  function automatic logic [19:0] mk(input logic [4:0] op, input logic [4:0] vop);
    return {1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, op, vop, 1'b0, 1'b0};
  endfunction

  localparam logic [127:0] ALL_FF = {16{8'hFF}};
  localparam logic [127:0] ALL_01 = {16{8'h01}};
  localparam logic [127:0] ALL_10 = {16{8'h10}};

  initial begin
    reset = 1'b0; ctrl_in = '0; srcA_in = '0; srcB_in = '0;
    srcA_vector_in = '0; srcB_vector_in = '0;
    rs1_decode = '0; rs2_decode = '0; rd_decode = '0;
    fwd_sel_a = '0; fwd_sel_b = '0; writeback_data = '0; alu_result_memory = '0;

    drive("reset", 1'b1, 20'hFFFFF, 16'hAAAA, 16'h5555, ALL_FF, ALL_01, 5'd3, 5'd4, 5'd5,
          2'b00, 2'b00, 16'h1111, 16'h2222);
    drive("add", 1'b0, mk(5'd0, 5'd0), 16'h1234, 16'h0F0F, 128'd0, 128'd0, 5'd1, 5'd2, 5'd3,
          2'b00, 2'b00, 16'h0, 16'h0);
    drive("sub_wrap", 1'b0, mk(5'd1, 5'd1), 16'h0000, 16'h0001, ALL_01, ALL_FF, 5'd4, 5'd5, 5'd6,
          2'b00, 2'b00, 16'h0, 16'h0);
    drive("forward", 1'b0, mk(5'd0, 5'd9), 16'h7777, 16'h9999, ALL_10, ALL_01, 5'd7, 5'd8, 5'd9,
          2'b01, 2'b10, 16'h0005, 16'h0003);
    drive("vec_add", 1'b0, mk(5'd3, 5'd0), 16'h00F0, 16'h000F, ALL_FF, ALL_01, 5'd10, 5'd11, 5'd12,
          2'b11, 2'b00, 16'hDEAD, 16'hBEEF);
    drive("vec_mul", 1'b0, mk(5'd9, 5'd5), 16'h0100, 16'h0101, ALL_10, ALL_10, 5'd13, 5'd14, 5'd15,
          2'b00, 2'b11, 16'h0, 16'h0);
    drive("ctrl_ones", 1'b0, 20'hFFFFF, 16'h1234, 16'h5678, ALL_FF, ALL_FF, 5'd16, 5'd17, 5'd18,
          2'b00, 2'b00, 16'h0, 16'h0);
    drive("bubble", 1'b0, 20'h00000, 16'h4321, 16'h1111, ALL_01, ALL_01, 5'd19, 5'd20, 5'd21,
          2'b00, 2'b00, 16'h0, 16'h0);
    drive("pre_reset", 1'b0, mk(5'd4, 5'd4), 16'hF0F0, 16'h0FF0, ALL_10, ALL_FF, 5'd22, 5'd23, 5'd24,
          2'b00, 2'b00, 16'h0, 16'h0);
    drive("mid_reset", 1'b1, mk(5'd2, 5'd2), 16'hFFFF, 16'hFFFF, ALL_FF, ALL_FF, 5'd25, 5'd26, 5'd27,
          2'b00, 2'b00, 16'h0, 16'h0);

    for (int i = 0; i < 60; i++) begin
      logic [19:0] c;
      c = 20'($urandom);
      c[11:7] = 5'($urandom_range(0, 12));
      c[6:2]  = 5'($urandom_range(0, 11));
      drive($sformatf("rand%0d", i), 1'b0, c, 16'($urandom), 16'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
            5'($urandom), 5'($urandom), 5'($urandom), 2'($urandom), 2'($urandom),
            16'($urandom), 16'($urandom));
    end

    check("scoreboard_drained", 128'(sb_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
